// File: rtl/dot_prod_pkg.sv
// Shared types and default sizing for the parallel dot-product engine.
package dot_prod_pkg;

  localparam int unsigned DEF_DATA_W = 27;
  localparam int unsigned DEF_ADDR_W = 10;
  localparam int unsigned DEF_LANES  = 4;
  localparam int unsigned DEF_RES_W  = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/dpp_bank.sv
// Single element bank: one write port, one registered read port.
// Contents are deliberately not reset so host-loaded data survives a reset.
module dpp_bank #(
  parameter int unsigned DATA_W = 27,
  parameter int unsigned WORD_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [WORD_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [WORD_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**WORD_W];

  // Write on strobe, read every cycle with one cycle latency.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/dot_prod_par.sv
// Parallel dot-product engine: LANES elements of A and B per cycle are read
// from interleaved banks, multiplied, summed and accumulated onto init_acc.
module dot_prod_par
  import dot_prod_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned LANES  = DEF_LANES,
  parameter int unsigned RES_W  = DEF_RES_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ctrl_arr,
  input  logic              arr_we,
  input  logic [ADDR_W-1:0] arr_addr,
  input  logic [DATA_W-1:0] arr_wdata_a,
  input  logic [DATA_W-1:0] arr_wdata_b,
  output logic [DATA_W-1:0] arr_rdata_a,
  output logic [DATA_W-1:0] arr_rdata_b,
  input  logic              r_enable,
  input  logic [ADDR_W:0]   len,
  input  logic [RES_W-1:0]  init_acc,
  input  logic              unsigned_mode,
  output logic              busy,
  output logic              w_enable,
  output logic [RES_W-1:0]  result
);

  localparam int unsigned LOG_L  = $clog2(LANES);
  localparam int unsigned LANE_W = (LOG_L > 0) ? LOG_L : 1;
  localparam int unsigned WORD_W = ADDR_W - LOG_L;
  localparam int unsigned PROD_W = 2 * DATA_W + 2;

  state_t state, state_nx;

  logic              busy_i;
  logic              start;
  logic              host_en;
  logic [ADDR_W:0]   len_q;
  logic              um_q;
  logic [WORD_W-1:0] beat_q;
  logic [WORD_W-1:0] last_beat;
  logic              v1_q;
  logic              v2_q;
  logic [LANES-1:0]  mask_c;
  logic [LANES-1:0]  mask1_q;
  logic [RES_W-1:0]  acc_q;
  logic [RES_W-1:0]  result_q;
  logic              w_en_q;
  logic [RES_W-1:0]  lane_sum;
  logic [WORD_W-1:0] bank_raddr;
  logic [WORD_W-1:0] host_word;
  logic [LANE_W-1:0] host_lane;
  logic [LANE_W-1:0] host_lane_q;

  logic [DATA_W-1:0] rd_a   [LANES];
  logic [DATA_W-1:0] rd_b   [LANES];
  logic [RES_W-1:0]  prod_c [LANES];
  logic [RES_W-1:0]  prod_q [LANES];

  // busy stays high through the w_enable cycle, which follows DONE by one edge.
  assign busy_i  = (state != IDLE) || w_en_q;
  assign start   = r_enable && !ctrl_arr && !busy_i;
  assign host_en = ctrl_arr && !busy_i;

  assign host_lane  = LANE_W'(arr_addr % LANES);
  assign host_word  = WORD_W'(arr_addr >> LOG_L);
  assign last_beat  = WORD_W'((len_q - (ADDR_W + 1)'(1)) >> LOG_L);
  assign bank_raddr = (state == RUN) ? beat_q : host_word;

  // Element i lives in bank (i mod LANES) at word (i / LANES).
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic we_g;
    assign we_g = host_en && arr_we && (host_lane == LANE_W'(g));

    dpp_bank #(.DATA_W(DATA_W), .WORD_W(WORD_W)) u_bank_a (
      .clk   (clk),
      .we    (we_g),
      .waddr (host_word),
      .wdata (arr_wdata_a),
      .raddr (bank_raddr),
      .rdata (rd_a[g])
    );

    dpp_bank #(.DATA_W(DATA_W), .WORD_W(WORD_W)) u_bank_b (
      .clk   (clk),
      .we    (we_g),
      .waddr (host_word),
      .wdata (arr_wdata_b),
      .raddr (bank_raddr),
      .rdata (rd_b[g])
    );
  end

  // Remember which lane the host read targeted so the bank output can be muxed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) host_lane_q <= '0;
    else        host_lane_q <= host_lane;
  end

  assign arr_rdata_a = rd_a[host_lane_q];
  assign arr_rdata_b = rd_b[host_lane_q];

  // Next-state logic; DRAIN leaves once the last bank beat has moved on.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = (len == '0) ? DONE : RUN;
      RUN:     if (beat_q == last_beat) state_nx = DRAIN;
      DRAIN:   if (!v1_q) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register, operand capture and beat counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      len_q  <= '0;
      um_q   <= 1'b0;
      beat_q <= '0;
      w_en_q <= 1'b0;
    end else begin
      state  <= state_nx;
      w_en_q <= (state == DONE);
      if (start) begin
        len_q  <= len;
        um_q   <= unsigned_mode;
        beat_q <= '0;
      end else if (state == RUN) begin
        beat_q <= beat_q + WORD_W'(1);
      end
    end
  end

  // Per-lane validity: element index of this beat must be below len.
  always_comb begin
    logic [ADDR_W:0] elem_idx;
    elem_idx = '0;
    mask_c   = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      elem_idx  = ((ADDR_W + 1)'(beat_q) << LOG_L) + (ADDR_W + 1)'(l);
      mask_c[l] = (elem_idx < len_q);
    end
  end

  // Extend each operand by one bit (sign or zero) so a single signed
  // multiplier covers both modes; the product is then sign-extended to RES_W.
  always_comb begin
    logic signed [DATA_W:0]   ea;
    logic signed [DATA_W:0]   eb;
    logic signed [PROD_W-1:0] full;
    ea   = '0;
    eb   = '0;
    full = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      ea        = {(um_q ? 1'b0 : rd_a[l][DATA_W-1]), rd_a[l]};
      eb        = {(um_q ? 1'b0 : rd_b[l][DATA_W-1]), rd_b[l]};
      full      = ea * eb;
      prod_c[l] = RES_W'(full);
    end
  end

  // Pipeline valids and lane masks follow the bank read and product stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      mask1_q <= '0;
    end else begin
      v1_q    <= (state == RUN);
      v2_q    <= v1_q;
      mask1_q <= mask_c;
    end
  end

  // Product registers; lanes past len are forced to zero here.
  always_ff @(posedge clk) begin
    for (int unsigned l = 0; l < LANES; l++) begin
      prod_q[l] <= mask1_q[l] ? prod_c[l] : '0;
    end
  end

  // Adder tree across lanes, wrapping modulo 2^RES_W.
  always_comb begin
    lane_sum = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      lane_sum = lane_sum + prod_q[l];
    end
  end

  // Accumulator seeded at start; result latched from it in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      if (start)     acc_q <= init_acc;
      else if (v2_q) acc_q <= acc_q + lane_sum;
      if (state == DONE) result_q <= acc_q;
    end
  end

  assign busy     = busy_i;
  assign w_enable = w_en_q;
  assign result   = result_q;

endmodule

// File: tb/tb_dot_prod_par.sv
// Bench for dot_prod_par: vector table plus hand sequences, with a
// scoreboard queue of expected results and latencies.
module tb_dot_prod_par;

  localparam int DATA_W = 27;
  localparam int ADDR_W = 10;
  localparam int LANES  = 4;
  localparam int RES_W  = 64;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ctrl_arr = 1'b0;
  logic              arr_we = 1'b0;
  logic [ADDR_W-1:0] arr_addr = '0;
  logic [DATA_W-1:0] wa = '0, wb = '0, ra, rb;
  logic              r_enable = 1'b0;
  logic [ADDR_W:0]   len = '0;
  logic [RES_W-1:0]  init_acc = '0;
  logic              unsigned_mode = 1'b0;
  logic              busy, w_enable;
  logic [RES_W-1:0]  result;

  always #5 clk = ~clk;

  dot_prod_par #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LANES(LANES), .RES_W(RES_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ctrl_arr      (ctrl_arr),
    .arr_we        (arr_we),
    .arr_addr      (arr_addr),
    .arr_wdata_a   (wa),
    .arr_wdata_b   (wb),
    .arr_rdata_a   (ra),
    .arr_rdata_b   (rb),
    .r_enable      (r_enable),
    .len           (len),
    .init_acc      (init_acc),
    .unsigned_mode (unsigned_mode),
    .busy          (busy),
    .w_enable      (w_enable),
    .result        (result)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [DATA_W-1:0] ma [DEPTH];
  logic [DATA_W-1:0] mb [DEPTH];

  typedef struct { logic [RES_W-1:0] res; int lat; } exp_t;
  exp_t sb_q[$];

  typedef struct { int len; logic [RES_W-1:0] init; bit um; logic [RES_W-1:0] exp; int lat; } vec_t;
  vec_t vt[7];

  task automatic check(input string name, input logic [RES_W-1:0] act, input logic [RES_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic write_elem(input int i, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    @(negedge clk);
    ctrl_arr = 1'b1; arr_we = 1'b1; r_enable = 1'b0;
    arr_addr = ADDR_W'(i); wa = a; wb = b;
    ma[i] = a; mb[i] = b;
    @(posedge clk);
    #1 arr_we = 1'b0;
  endtask

  task automatic read_check(input int i);
    @(negedge clk);
    ctrl_arr = 1'b1; arr_we = 1'b0; arr_addr = ADDR_W'(i);
    @(posedge clk);
    @(negedge clk);
    check($sformatf("rd_a[%0d]", i), RES_W'(ra), RES_W'(ma[i]));
    check($sformatf("rd_b[%0d]", i), RES_W'(rb), RES_W'(mb[i]));
  endtask

  function automatic logic [RES_W-1:0] model(input int n, input logic [RES_W-1:0] init, input bit um);
    logic [RES_W-1:0] s;
    longint pa, pb;
    s = init;
    for (int i = 0; i < n; i++) begin
      if (um) begin
        pa = longint'({37'd0, ma[i]});
        pb = longint'({37'd0, mb[i]});
      end else begin
        pa = longint'($signed(ma[i]));
        pb = longint'($signed(mb[i]));
      end
      s = s + RES_W'(pa * pb);
    end
    return s;
  endfunction

  // Start one operation, scramble the captured inputs while busy, and
  // compare result/latency against the scoreboard entry.
  task automatic run_op(input string name, input int n, input logic [RES_W-1:0] init, input bit um,
                        input logic [RES_W-1:0] exp_res, input int exp_lat, input bit disturb);
    exp_t e;
    int edges;
    bit got;
    sb_q.push_back('{exp_res, exp_lat});
    @(negedge clk);
    ctrl_arr = 1'b0; arr_we = 1'b0; r_enable = 1'b1;
    len = (ADDR_W + 1)'(n); init_acc = init; unsigned_mode = um;
    @(posedge clk);
    @(negedge clk);
    r_enable = disturb;
    len = (ADDR_W + 1)'($urandom_range(1, DEPTH));
    init_acc = {$urandom, $urandom};
    unsigned_mode = ~um;
    if (disturb) begin
      ctrl_arr = 1'b1; arr_we = 1'b1; arr_addr = '0;
      wa = 27'h5A5A5A5; wb = 27'h1234567;
    end
    check({name, " busy"}, RES_W'(busy), RES_W'(1));
    edges = 0;
    got = 1'b0;
    while (edges < 400 && !got) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (w_enable) got = 1'b1;
    end
    r_enable = 1'b0; arr_we = 1'b0; ctrl_arr = 1'b0;
    e = sb_q.pop_front();
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: w_enable not seen in 400 edges, expected after %0d", name, e.lat);
    end else begin
      check({name, " result"}, result, e.res);
      check({name, " latency"}, RES_W'(edges), RES_W'(e.lat));
      @(posedge clk);
      @(negedge clk);
      check({name, " w_en_drop"}, RES_W'(w_enable), RES_W'(0));
      check({name, " idle"}, RES_W'(busy), RES_W'(0));
      check({name, " hold"}, result, e.res);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wcount;
    logic [RES_W-1:0] exp_rand;

    vt[0] = '{8, 64'd0,         1'b0, 64'd72,          5};
    vt[1] = '{6, 64'd0,         1'b0, 64'd42,          5};
    vt[2] = '{0, -64'sd5,       1'b0, -64'sd5,         1};
    vt[3] = '{1, 64'd0,         1'b0, 64'd2,           4};
    vt[4] = '{5, 64'd0,         1'b0, 64'd30,          5};
    vt[5] = '{3, -64'sd100,     1'b1, -64'sd88,        4};
    vt[6] = '{4, 64'd10,        1'b1, 64'd30,          4};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset busy", RES_W'(busy), RES_W'(0));
    check("reset w_en", RES_W'(w_enable), RES_W'(0));
    check("reset result", result, '0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) write_elem(i, DATA_W'(i + 1), DATA_W'(2));
    for (int i = 8; i < 12; i++) write_elem(i, DATA_W'(100), DATA_W'(100));
    read_check(3);
    read_check(9);

    for (int k = 0; k < 7; k++)
      run_op($sformatf("vec%0d", k), vt[k].len, vt[k].init, vt[k].um, vt[k].exp, vt[k].lat, 1'b0);

    // Start request while the host owns the arrays is ignored
    @(negedge clk);
    ctrl_arr = 1'b1; r_enable = 1'b1; len = 11'd8;
    @(posedge clk);
    @(negedge clk);
    check("ctrl_arr blocks start", RES_W'(busy), RES_W'(0));
    r_enable = 1'b0;

    // r_enable and arr_we held during a run are ignored
    run_op("disturb", 8, 64'd0, 1'b0, 64'd72, 5, 1'b1);
    @(negedge clk);
    check("no restart", RES_W'(busy), RES_W'(0));
    read_check(0);

    // Extreme negative element, signed and unsigned
    write_elem(0, 27'h4000000, 27'h4000000);
    run_op("minneg s", 1, 64'd0, 1'b0, 64'h0010_0000_0000_0000, 4, 1'b0);
    run_op("minneg u", 1, 64'd0, 1'b1, 64'h0010_0000_0000_0000, 4, 1'b0);
    write_elem(0, 27'h7FFFFFF, 27'd1);
    run_op("allones s", 1, 64'd0, 1'b0, -64'sd1, 4, 1'b0);
    run_op("allones u", 1, 64'd0, 1'b1, 64'h0000_0000_07FF_FFFF, 4, 1'b0);

    // Full-depth random vectors
    for (int i = 0; i < DEPTH; i++) write_elem(i, DATA_W'($urandom), DATA_W'($urandom));
    exp_rand = model(DEPTH, 64'd100, 1'b0);
    run_op("rand1024", DEPTH, 64'd100, 1'b0, exp_rand, 259, 1'b0);
    run_op("rand1023 u", DEPTH - 1, 64'd0, 1'b1, model(DEPTH - 1, 64'd0, 1'b1), 259, 1'b0);
    run_op("rand13", 13, -64'sd7, 1'b0, model(13, -64'sd7, 1'b0), 7, 1'b0);

    // Reset in the middle of a run aborts it
    @(negedge clk);
    ctrl_arr = 1'b0; r_enable = 1'b1; len = 11'd1024; init_acc = 64'd100; unsigned_mode = 1'b0;
    @(posedge clk);
    @(negedge clk);
    r_enable = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort busy", RES_W'(busy), RES_W'(0));
    check("abort w_en", RES_W'(w_enable), RES_W'(0));
    check("abort result", result, '0);
    @(negedge clk);
    rst_n = 1'b1;
    wcount = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (w_enable) wcount++;
    end
    check("abort no w_en", RES_W'(wcount), RES_W'(0));
    run_op("restart", DEPTH, 64'd100, 1'b0, exp_rand, 259, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
